noc_output_arbiter: RTL and testbench
=====================================

// Module: noc_output_arbiter
// PURPOSE
//  Router output-port stage directly downstream of the per-input synchronous FIFOs.
//  - Round-robin arbitrates N_IN show-ahead FIFOs.
//  - Pops one flit per cycle from the winner into a registered valid/ready output.
//  - Holds the grant (packet lock) from head flit to tail flit so packets never interleave.
// PARAMETERS
//  N_IN    4  number of input FIFOs arbitrated (>=2)
//  DATA_W  8  flit width; bit DATA_W-1 is the tail flag, bits DATA_W-2:0 are payload
// PORTS
//  i_clk         in   1             single clock; all state updates on rising edge
//  i_srst        in   1             reset, synchronous, active-high
//  i_fifoEmpty   in   N_IN          per-FIFO empty flag
//  i_fifoData    in   N_IN x DATA_W per-FIFO head flit (show-ahead: valid while !empty)
//  o_fifoReadEn  out  N_IN          per-FIFO pop strobe (combinational)
//  o_valid       out  1             output flit valid (registered)
//  o_data        out  DATA_W        output flit (registered)
//  i_ready       in   1             downstream accepts o_data when o_valid && i_ready
//  o_locked      out  1             packet lock held (registered)
//  o_owner       out  max(1,$clog2(N_IN))  index of locked input (registered)
// BEHAVIOUR
//  Reset (i_srst=1 at an edge): o_valid=0, o_data=0, o_locked=0, o_owner=0, rrPtr=0.
//  - o_fifoReadEn is forced to 0 while i_srst=1.
//  Slot free: slotFree = !o_valid || i_ready.
//  Request: req[i] = !i_fifoEmpty[i].
//  Unlocked selection: winner = first i with req[i], searching rrPtr, rrPtr+1, ... mod N_IN.
//  Locked selection: only o_owner is eligible.
//  - Owner empty: no pop (bubble); lock is kept.
//  - Other FIFOs are never popped while locked.
//  Pop: if slotFree and an eligible winner g exists:
//  - o_fifoReadEn[g]=1 this cycle.
//  - At the edge: o_data<=i_fifoData[g], o_valid<=1.
//  - o_fifoReadEn is at most one-hot and is never asserted to an empty FIFO or when !slotFree.
//  No pop: if slotFree and no pop, o_valid<=0 and o_data holds.
//  Stall: if !slotFree, o_valid and o_data hold and nothing pops.
//  Lock update on a pop from g:
//  - tail=0, unlocked: o_locked<=1, o_owner<=g.
//  - tail=0, locked: no change.
//  - tail=1: o_locked<=0, rrPtr<=(g+1) mod N_IN. This covers single-flit packets and ends held packets.
//  - rrPtr changes only on a tail pop.
//  Latency and throughput:
//  - Pop to o_valid is 1 cycle.
//  - Sustained rate is 1 flit/cycle with i_ready=1 and the selected FIFO non-empty.
//  Wrap-around: rrPtr=N_IN-1 and a tail pop from N_IN-1 gives rrPtr=0.
//  Simultaneous events: handshake completion and a new pop in the same cycle are legal; o_valid stays 1.
//  Reset mid-packet: lock and output are dropped. The partial packet is discarded downstream; the FIFOs are reset alongside.
// TESTING
//  T1 reset: i_srst=1 for 2 cycles, all FIFOs non-empty.
//  - Required: o_fifoReadEn=0, o_valid=0, o_data=0, o_locked=0.
//  - Then first pop goes to FIFO0.
//  T2 round robin: FIFOk holds one flit 0x80|k (k=0..3), i_ready=1.
//  - Required: pops 0,1,2,3 on consecutive cycles.
//  - o_data = 0x80,0x81,0x82,0x83 one cycle later, o_valid continuously high.
//  T3 packet lock: rrPtr=1; FIFO1 holds 0x11,0x12,0x93; FIFO0 holds 0x85; FIFO2 holds 0x86.
//  - Required output order: 0x11,0x12,0x93,0x86,0x85.
//  - o_locked=1 from the edge of the 0x11 pop through the edge of the 0x93 pop.
//  T4 lock bubble: owner FIFO empty for 3 cycles mid-packet, others non-empty.
//  - Required: no o_fifoReadEn, o_valid=0 for those cycles, lock held, then 0x93 tail resumes.
//  T5 backpressure: i_ready=0 for 5 cycles while o_valid=1.
//  - Required: o_data stable and no pops.
//  - On i_ready=1, the flit transfers once and the next flit follows; no loss or duplication.
//  T6 wrap: rrPtr=3, FIFO3 and FIFO0 each hold one tail flit.
//  - Required: FIFO3 is granted first, then rrPtr=0 and FIFO0 is granted next.

Source files
------------

// File: rtl/noc_output_arbiter_if.sv
// noc_output_arbiter_if
//   Bundles the arbiter's FIFO-side and output-side signals.
//   FIFO side  : i_fifoEmpty / i_fifoData (show-ahead heads), o_fifoReadEn (pop strobes)
//   Output side: o_valid / o_data / i_ready handshake, plus o_locked / o_owner status
//   modport master : the arbiter
//   modport slave  : the FIFOs plus the downstream consumer
interface noc_output_arbiter_if #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 8
);
  localparam int OWN_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [N_IN-1:0]             i_fifoEmpty;
  logic [N_IN-1:0][DATA_W-1:0] i_fifoData;
  logic [N_IN-1:0]             o_fifoReadEn;
  logic                        o_valid;
  logic [DATA_W-1:0]           o_data;
  logic                        i_ready;
  logic                        o_locked;
  logic [OWN_W-1:0]            o_owner;

  modport master (
    input  i_fifoEmpty, i_fifoData, i_ready,
    output o_fifoReadEn, o_valid, o_data, o_locked, o_owner
  );

  modport slave (
    output i_fifoEmpty, i_fifoData, i_ready,
    input  o_fifoReadEn, o_valid, o_data, o_locked, o_owner
  );
endinterface

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter
//   Router output stage: round-robin arbitration over N_IN show-ahead FIFOs,
//   popping at most one flit per cycle into a registered valid/ready output.
//   A head flit locks the grant to its FIFO until that FIFO's tail flit
//   (bit DATA_W-1 set) is popped, so packets never interleave.
// Ports
//   i_clk  : clock, rising edge
//   i_srst : synchronous active-high reset
//   bus    : noc_output_arbiter_if.master
//            i_fifoEmpty, i_fifoData -> FIFO heads; o_fifoReadEn -> pop strobes
//            o_valid, o_data, i_ready -> output handshake
//            o_locked, o_owner -> packet-lock status
module noc_output_arbiter #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_srst,
  noc_output_arbiter_if.master bus
);
  localparam int OWN_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

  lock_state_t       state_p1, state_nxt;
  logic [OWN_W-1:0]  owner_p1, owner_nxt;
  logic [OWN_W-1:0]  rr_ptr, rr_nxt;
  logic [OWN_W-1:0]  win;
  logic              win_found;
  logic              win_tail;
  logic              slot_free;
  logic              pop;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;

  // Next round-robin start after a tail from idx, wrapping at N_IN.
  function automatic logic [OWN_W-1:0] wrap_inc(input logic [OWN_W-1:0] idx);
    return (idx == OWN_W'(N_IN - 1)) ? '0 : idx + OWN_W'(1);
  endfunction

  // Stage p0: selection and pop decision
  assign slot_free = !vld_p1 || bus.i_ready;

  always_comb begin
    int idx;
    idx       = 0;
    win       = '0;
    win_found = 1'b0;
    if (state_p1 == ST_LOCKED) begin
      win       = owner_p1;
      win_found = !bus.i_fifoEmpty[owner_p1];
    end else begin
      // Scan from the farthest offset down so the nearest requester to
      // rr_ptr is the last (winning) assignment.
      for (int k = N_IN - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_IN) idx = idx - N_IN;
        if (!bus.i_fifoEmpty[OWN_W'(idx)]) begin
          win       = OWN_W'(idx);
          win_found = 1'b1;
        end
      end
    end
  end

  assign pop      = slot_free && win_found && !i_srst;
  assign win_tail = bus.i_fifoData[win][DATA_W-1];

  always_comb begin
    bus.o_fifoReadEn = '0;
    if (pop) bus.o_fifoReadEn[win] = 1'b1;
  end

  always_comb begin
    state_nxt = state_p1;
    owner_nxt = owner_p1;
    rr_nxt    = rr_ptr;
    if (pop) begin
      if (win_tail) begin
        state_nxt = ST_OPEN;
        rr_nxt    = wrap_inc(win);
      end else if (state_p1 == ST_OPEN) begin
        state_nxt = ST_LOCKED;
        owner_nxt = win;
      end
    end
  end

  // Stage p1: output register and lock state
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      state_p1 <= ST_OPEN;
      owner_p1 <= '0;
      rr_ptr   <= '0;
    end else begin
      state_p1 <= state_nxt;
      owner_p1 <= owner_nxt;
      rr_ptr   <= rr_nxt;
      if (slot_free) vld_p1 <= pop;
      if (pop) data_p1 <= bus.i_fifoData[win];
    end
  end

  assign bus.o_valid  = vld_p1;
  assign bus.o_data   = data_p1;
  assign bus.o_locked = (state_p1 == ST_LOCKED);
  assign bus.o_owner  = owner_p1;
endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter
//   FIFOs are modelled as queues. Each cycle a reference model picks which
//   FIFO must be popped from packet-level rules (round-robin start, packet
//   ownership until tail) and pushes the popped flit into a scoreboard; an
//   independent monitor pops the scoreboard on every output handshake.
module tb_noc_output_arbiter;
  localparam int N_IN   = 4;
  localparam int DATA_W = 8;

  logic i_clk = 1'b0;
  logic i_srst;
  always #5 i_clk = ~i_clk;

  noc_output_arbiter_if #(.N_IN(N_IN), .DATA_W(DATA_W)) bus();

  noc_output_arbiter #(.N_IN(N_IN), .DATA_W(DATA_W)) dut (
    .i_clk  (i_clk),
    .i_srst (i_srst),
    .bus    (bus)
  );

  logic [DATA_W-1:0] fq [N_IN][$];
  logic [DATA_W-1:0] sb[$];
  logic [DATA_W-1:0] out_log[$];
  bit m_locked = 1'b0;
  bit m_vld    = 1'b0;
  int m_owner  = 0;
  int m_rr     = 0;
  bit tb_ready;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted flit must be the oldest expected one.
  always @(negedge i_clk) begin
    if (i_srst === 1'b0 && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got flit %0h, expected no output", bus.o_data);
      end else begin
        chk("sb_data", 32'(bus.o_data), 32'(sb.pop_front()));
      end
      out_log.push_back(bus.o_data);
    end
  end

  // One clock of stimulus + model. Entered and left 1 time unit after a rising edge.
  task automatic step();
    int g;
    bit pop;
    bit rdy;
    logic [N_IN-1:0] exp_rd;
    logic [DATA_W-1:0] f;
    for (int i = 0; i < N_IN; i++) begin
      bus.i_fifoEmpty[i] = (fq[i].size() == 0);
      bus.i_fifoData[i]  = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
    rdy = tb_ready;
    bus.i_ready = rdy;
    g = -1;
    if (m_locked) begin
      if (fq[m_owner].size() != 0) g = m_owner;
    end else begin
      for (int k = 0; k < N_IN; k++)
        if (g < 0 && fq[(m_rr + k) % N_IN].size() != 0) g = (m_rr + k) % N_IN;
    end
    pop = !i_srst && (g >= 0) && (!m_vld || rdy);
    exp_rd = '0;
    if (pop) exp_rd[g] = 1'b1;

    @(negedge i_clk);
    chk("read_en", 32'(bus.o_fifoReadEn), 32'(exp_rd));
    if (!i_srst) begin
      chk("valid", 32'(bus.o_valid), 32'(m_vld));
      chk("locked", 32'(bus.o_locked), 32'(m_locked));
      if (m_locked) chk("owner", 32'(bus.o_owner), 32'(m_owner));
      if (m_vld && !rdy) chk("stall_data", 32'(bus.o_data), 32'(sb[0]));
    end

    @(posedge i_clk);
    if (i_srst) begin
      m_locked = 1'b0;
      m_owner  = 0;
      m_rr     = 0;
      m_vld    = 1'b0;
      sb.delete();
    end else if (!m_vld || rdy) begin
      if (pop) begin
        f = fq[g].pop_front();
        sb.push_back(f);
        m_vld = 1'b1;
        if (f[DATA_W-1]) begin
          m_locked = 1'b0;
          m_rr     = (g + 1) % N_IN;
        end else if (!m_locked) begin
          m_locked = 1'b1;
          m_owner  = g;
        end
      end else begin
        m_vld = 1'b0;
      end
    end
    #1;
  endtask

  // Run until everything queued has left the output; a stranded lock gets its tail.
  task automatic drain(input int maxc);
    int c;
    bit busy;
    c = 0;
    busy = 1'b1;
    while (busy && c < maxc) begin
      busy = m_vld;
      for (int i = 0; i < N_IN; i++) if (fq[i].size() != 0) busy = 1'b1;
      if (m_locked && fq[m_owner].size() == 0) fq[m_owner].push_back(8'hFF);
      if (busy) begin
        step();
        c++;
      end
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got busy after %0d cycles, expected idle", c);
    end
  endtask

  // Compare accepted flits against n expected bytes packed MSB-first in v.
  task automatic chk_log(input string name, input int n, input logic [63:0] v);
    chk({name, "_len"}, 32'(out_log.size()), 32'(n));
    for (int i = 0; i < n && i < out_log.size(); i++)
      chk(name, 32'(out_log[i]), 32'(v[8*(n-1-i) +: 8]));
  endtask

  initial begin
    bus.i_fifoEmpty = '1;
    bus.i_fifoData  = '0;
    bus.i_ready     = 1'b1;
    tb_ready        = 1'b1;

    // T1 reset with every FIFO holding data, then T2 round robin
    i_srst = 1'b1;
    for (int k = 0; k < N_IN; k++) fq[k].push_back(8'(8'h80 | k));
    step();
    step();
    i_srst = 1'b0;
    chk("rst_data", 32'(bus.o_data), 32'h0);
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_locked", 32'(bus.o_locked), 32'h0);
    chk("rst_owner", 32'(bus.o_owner), 32'h0);
    out_log.delete();
    drain(50);
    chk_log("t2_order", 4, 64'h80818283);

    // T3 packet lock starting from rrPtr=1
    fq[0].push_back(8'hC0);
    drain(20);
    out_log.delete();
    fq[1].push_back(8'h11);
    fq[1].push_back(8'h12);
    fq[1].push_back(8'h93);
    fq[0].push_back(8'h85);
    fq[2].push_back(8'h86);
    drain(50);
    chk_log("t3_order", 5, 64'h1112938685);

    // T4 owner runs dry mid-packet for 3 cycles
    out_log.delete();
    fq[1].push_back(8'h11);
    fq[1].push_back(8'h12);
    fq[0].push_back(8'h85);
    fq[2].push_back(8'h86);
    step();
    step();
    repeat (3) step();
    fq[1].push_back(8'h93);
    drain(50);
    chk_log("t4_order", 5, 64'h1112938685);

    // T5 backpressure for 5 cycles
    out_log.delete();
    fq[2].push_back(8'h21);
    fq[2].push_back(8'h22);
    fq[2].push_back(8'hA3);
    step();
    tb_ready = 1'b0;
    repeat (5) step();
    tb_ready = 1'b1;
    drain(50);
    chk_log("t5_order", 3, 64'h2122A3);

    // T6 wrap from rrPtr=3
    out_log.delete();
    fq[3].push_back(8'hB3);
    fq[0].push_back(8'hB0);
    drain(20);
    chk_log("t6_order", 2, 64'hB3B0);

    // Randomized traffic with backpressure and one mid-stream reset
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        i_srst = 1'b1;
        step();
        i_srst = 1'b0;
        for (int i = 0; i < N_IN; i++) fq[i].delete();
      end
      for (int i = 0; i < N_IN; i++)
        if (fq[i].size() < 6 && $urandom_range(0, 9) < 3)
          fq[i].push_back({($urandom_range(0, 2) == 0), 7'($urandom)});
      tb_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    tb_ready = 1'b1;
    drain(300);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
